// File: rtl/pico_mem_fabric.sv
// Single-master to NUM_SLAVES bridge for the picorv32 native memory interface:
// address decode, per-access ready timeout and sticky bus-error reporting.
module pico_mem_fabric #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_BITS   = 2,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    input  logic                     m_instr,
    output logic                     m_ready,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic                     s_instr,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_flag,
    output logic [31:0]              err_addr,
    input  logic                     err_clr
);

    localparam int NUM_IDX = 2 ** SEL_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;

    state_t              state;
    state_t              next_state;
    logic [SEL_BITS-1:0] req_idx;
    logic [SEL_BITS-1:0] idx_q;
    logic [NUM_IDX-1:0]  idx_mapped;
    logic [15:0]         cnt;
    logic                timeout_hit;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    assign req_idx     = m_addr[31 -: SEL_BITS];
    assign timeout_hit = (cnt == 16'(TIMEOUT - 1));
    assign m_ready     = (state == RESP);

    // Indices past NUM_SLAVES decode to nothing and take the error path.
    always_comb begin
        for (int i = 0; i < NUM_IDX; i++) begin
            idx_mapped[i] = (i < NUM_SLAVES);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_BITS'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        s_valid = '0;
        if (state == ACCESS) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                s_valid[i] = (idx_q == SEL_BITS'(i));
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    next_state = idx_mapped[req_idx] ? ACCESS : ERROR;
                end
            end
            ACCESS: begin
                // Ready on the final counted cycle still completes normally.
                if (sel_ready) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    next_state = ERROR;
                end
            end
            ERROR:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            s_instr  <= 1'b0;
            cnt      <= '0;
            m_rdata  <= '0;
            err_flag <= 1'b0;
            err_addr <= '0;
        end else begin
            if (state == IDLE && m_valid) begin
                idx_q   <= req_idx;
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                s_instr <= m_instr;
            end

            cnt <= (state == ACCESS) ? cnt + 16'd1 : '0;

            if (state == ACCESS && sel_ready) begin
                m_rdata <= sel_rdata;
            end else if (state == ERROR) begin
                m_rdata <= ERR_RDATA;
            end

            // A new error outranks a simultaneous clear.
            if (state == ERROR) begin
                err_flag <= 1'b1;
                err_addr <= s_addr;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pico_mem_fabric.sv
// Randomized bench for pico_mem_fabric: a transaction-level model predicts
// per-cycle s_valid/m_ready/m_rdata and the sticky error state.
module tb_pico_mem_fabric;

    localparam int          NS  = 3;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk;
    logic            rst;
    logic            m_valid;
    logic            m_instr;
    logic            m_ready;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [3:0]      m_wstrb;
    logic [31:0]     m_rdata;
    logic [NS-1:0]   s_valid;
    logic            s_instr;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [NS-1:0]   s_ready;
    logic [32*NS-1:0] s_rdata;
    logic            err_flag;
    logic [31:0]     err_addr;
    logic            err_clr;

    pico_mem_fabric #(
        .NUM_SLAVES (NS),
        .SEL_BITS   (2),
        .TIMEOUT    (TO),
        .ERR_RDATA  (ERR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_instr  (m_instr),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_instr  (s_instr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .err_flag (err_flag),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model expectations for the current cycle.
    bit          chk_en = 0;
    logic        exp_mready = 0;
    logic [NS-1:0] exp_svalid = '0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic        exp_instr = 0;
    logic        exp_err_flag = 0;
    logic [31:0] exp_err_addr = '0;

    // Observations of the last transaction, pinned against literals.
    int          obs_resp;
    int          obs_sv;
    logic [31:0] obs_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", 32'(m_ready), 32'(exp_mready));
            check("s_valid", 32'(s_valid), 32'(exp_svalid));
            if (exp_mready) check("m_rdata", m_rdata, exp_rdata);
            if (exp_svalid != '0) begin
                check("s_addr", s_addr, exp_addr);
                check("s_wdata", s_wdata, exp_wdata);
                check("s_wstrb", 32'(s_wstrb), 32'(exp_wstrb));
                check("s_instr", 32'(s_instr), 32'(exp_instr));
            end
            check("err_flag", 32'(err_flag), 32'(exp_err_flag));
            check("err_addr", err_addr, exp_err_addr);
        end
    end

    task automatic drive_slaves(input int tgt, input bit rdy, input logic [31:0] rd);
        for (int i = 0; i < NS; i++) begin
            s_ready[i]          = 1'($urandom);
            s_rdata[32*i +: 32] = $urandom;
        end
        if (tgt >= 0) begin
            s_ready[tgt] = rdy;
            if (rdy) s_rdata[32*tgt +: 32] = rd;
        end
    endtask

    // lat: ACCESS cycle (0-based) in which the slave raises ready; <0 = never.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr,
                           input int lat, input logic [31:0] rd, input bit clr_at_err);
        int          idx;
        bit          mapped;
        bit          is_err;
        int          n_acc;
        int          resp_c;
        logic [31:0] er;
        idx    = int'(addr[31:30]);
        mapped = (idx < NS);
        if (!mapped) begin
            n_acc = 0;       resp_c = 2;      is_err = 1; er = ERR;
        end else if (lat >= 0 && lat < TO) begin
            n_acc = lat + 1; resp_c = lat + 2; is_err = 0; er = rd;
        end else begin
            n_acc = TO;      resp_c = TO + 2; is_err = 1; er = ERR;
        end
        obs_resp  = -1;
        obs_sv    = 0;
        obs_rdata = '0;

        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; m_instr = instr;
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb; exp_instr = instr;
        exp_svalid = '0; exp_mready = 1'b0;
        drive_slaves(-1, 1'b0, '0);
        @(negedge clk);

        for (int c = 1; c <= resp_c; c++) begin
            @(posedge clk); #1;
            // Request fields change after capture; the fabric must hold its copies.
            m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom); m_instr = 1'($urandom);
            drive_slaves(mapped ? idx : -1, (c == lat + 1), rd);
            err_clr    = clr_at_err && is_err && (c == resp_c - 1);
            exp_svalid = (mapped && c <= n_acc) ? NS'(1 << idx) : '0;
            exp_mready = (c == resp_c);
            if (c == resp_c) begin
                exp_rdata = er;
                if (is_err) begin
                    exp_err_flag = 1'b1;
                    exp_err_addr = addr;
                end
            end
            @(negedge clk);
            if (m_ready && obs_resp < 0) begin
                obs_resp  = c;
                obs_rdata = m_rdata;
            end
            if (s_valid != '0) obs_sv++;
        end

        @(posedge clk); #1;
        m_valid = 1'b0; err_clr = 1'b0;
        exp_mready = 1'b0; exp_svalid = '0;
        drive_slaves(-1, 1'b0, '0);
        @(negedge clk);
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err_flag = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0;
        m_wstrb = '0; s_ready = '0; s_rdata = '0; err_clr = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_wdata", s_wdata, 32'h0);
        check("rst_s_wstrb", 32'(s_wstrb), 32'h0);
        check("rst_s_instr", 32'(s_instr), 32'h0);
        check("rst_err_flag", 32'(err_flag), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1;

        // Read to slave 0, ready in the first ACCESS cycle.
        run_txn(32'h1000_0004, 32'h0, 4'b0000, 1'b1, 0, 32'h1234_5678, 1'b0);
        check("read_latency", 32'(obs_resp), 32'd2);
        check("read_rdata", obs_rdata, 32'h1234_5678);
        check("read_svalid_cycles", 32'(obs_sv), 32'd1);

        // Write to slave 1, ready in the fifth ACCESS cycle.
        run_txn(32'h4000_0000, 32'hCAFE_F00D, 4'b0011, 1'b0, 4, 32'h5555_AAAA, 1'b0);
        check("write_svalid_cycles", 32'(obs_sv), 32'd5);
        check("write_latency", 32'(obs_resp), 32'd6);
        check("write_err_flag", 32'(err_flag), 32'h0);

        // Unmapped index 3.
        run_txn(32'hC000_0000, 32'h0, 4'b0000, 1'b0, 0, 32'h0, 1'b0);
        check("unmapped_latency", 32'(obs_resp), 32'd2);
        check("unmapped_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("unmapped_svalid_cycles", 32'(obs_sv), 32'd0);
        check("unmapped_err_flag", 32'(err_flag), 32'h1);
        check("unmapped_err_addr", err_addr, 32'hC000_0000);
        clear_err();

        // Slave 2 never ready, err_clr coinciding with ERROR.
        run_txn(32'h8000_0010, 32'h1111_2222, 4'b0000, 1'b0, -1, 32'h0, 1'b1);
        check("timeout_svalid_cycles", 32'(obs_sv), 32'd8);
        check("timeout_latency", 32'(obs_resp), 32'd10);
        check("timeout_rdata", obs_rdata, 32'hDEAD_BEEF);
        check("timeout_err_flag_set_wins", 32'(err_flag), 32'h1);
        clear_err();
        check("clr_err_flag", 32'(err_flag), 32'h0);
        check("clr_err_addr_kept", err_addr, 32'h8000_0010);

        // Ready on the last counted cycle wins over the timeout.
        run_txn(32'h8000_0020, 32'h0, 4'b0000, 1'b0, 7, 32'h0BAD_F00D, 1'b0);
        check("lastcycle_svalid_cycles", 32'(obs_sv), 32'd8);
        check("lastcycle_latency", 32'(obs_resp), 32'd9);
        check("lastcycle_rdata", obs_rdata, 32'h0BAD_F00D);
        check("lastcycle_no_err", 32'(err_flag), 32'h0);
        check("lastcycle_err_addr", err_addr, 32'h8000_0010);

        run_txn(32'hC000_0100, 32'h0, 4'b0000, 1'b0, 0, 32'h0, 1'b1);
        check("unmapped_clr_set_wins", 32'(err_flag), 32'h1);

        // Reset during the third ACCESS cycle of a stalled slave 2 access.
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h8000_0100; m_wdata = 32'h0; m_wstrb = 4'b0000; m_instr = 1'b0;
        exp_addr = m_addr; exp_wdata = m_wdata; exp_wstrb = m_wstrb; exp_instr = m_instr;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            drive_slaves(2, 1'b0, '0);
            exp_svalid = 3'b100;
            if (c == 3) begin
                rst = 1'b1; m_valid = 1'b0;
                exp_svalid = '0; exp_err_flag = 1'b0; exp_err_addr = '0;
                #1;
                check("rst_abort_svalid", 32'(s_valid), 32'h0);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_abort_err_flag", 32'(err_flag), 32'h0);
        run_txn(32'h0000_0040, 32'h0, 4'b0000, 1'b0, 0, 32'h7777_0001, 1'b0);
        check("post_rst_latency", 32'(obs_resp), 32'd2);
        check("post_rst_rdata", obs_rdata, 32'h7777_0001);

        // Randomized traffic across mapped, unmapped, stalled and timed-out accesses.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int          l;
            a = $urandom;
            l = int'($urandom_range(0, 10)) - 1;
            run_txn(a, $urandom, 4'($urandom), 1'($urandom), l, $urandom, 1'($urandom));
            if (n % 10 == 9) clear_err();
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pico_mem_fabric.md
PICO_MEM_FABRIC -- requirements
Module: pico_mem_fabric

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of slave ports, legal range 1..8.
REQ-002 Parameter SEL_BITS, default 2: slave index = m_addr[31 -: SEL_BITS]; requires 2**SEL_BITS >= NUM_SLAVES.
REQ-003 Parameter TIMEOUT, default 255: max cycles a slave may hold off ready, legal range 2..65535.
REQ-004 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 m_valid  in  1  master request (picorv32 native protocol).
REQ-008 m_instr  in  1  instruction-fetch qualifier, forwarded to s_instr.
REQ-009 m_ready  out  1  one-cycle response strobe to master.
REQ-010 m_addr  in  32 / m_wdata  in  32 / m_wstrb  in  4: request address, write data, byte strobes (0 = read).
REQ-011 m_rdata  out  32  response read data, valid while m_ready=1.
REQ-012 s_valid  out  NUM_SLAVES  one-hot slave request.
REQ-013 s_instr  out  1 / s_addr  out  32 / s_wdata  out  32 / s_wstrb  out  4: registered copies of the captured request, shared by all slaves.
REQ-014 s_ready  in  NUM_SLAVES  per-slave completion.
REQ-015 s_rdata  in  32*NUM_SLAVES  per-slave read data, slave i at bits [32*i +: 32].
REQ-016 err_flag  out  1  sticky bus-error indicator.
REQ-017 err_addr  out  32  address of the most recent errored request.
REQ-018 err_clr  in  1  synchronous clear of err_flag.

Function
REQ-019 FSM states: IDLE, ACCESS, ERROR, RESP.
REQ-020 IDLE with m_valid=1: capture addr, wdata, wstrb, instr and index; go to ACCESS if index < NUM_SLAVES, else go to ERROR.
REQ-021 ACCESS: s_valid[index]=1, all other bits 0; s_addr, s_wdata, s_wstrb and s_instr are held stable for the whole ACCESS state.
REQ-022 ACCESS with s_ready[index]=1: capture s_rdata slice into m_rdata and go to RESP; s_ready bits of non-selected slaves are ignored.
REQ-023 Timeout counter clears on entry to ACCESS and increments each ACCESS cycle; when it reaches TIMEOUT-1 without ready, go to ERROR and drop s_valid.
REQ-024 s_ready asserted in the same cycle the counter reaches TIMEOUT-1: ready wins, no error is raised.
REQ-025 ERROR lasts one cycle: set err_flag, load err_addr with the captured address, load m_rdata with ERR_RDATA, then go to RESP.
REQ-026 RESP: m_ready=1 for exactly one cycle, then IDLE; m_valid is not sampled for a new request in RESP.
REQ-027 Minimum latency is 2 cycles from m_valid sampled to m_ready high (slave ready in the first ACCESS cycle).
REQ-028 Unmapped index: m_ready rises 2 cycles after m_valid is sampled; no s_valid bit is ever asserted.
REQ-029 Writes (m_wstrb != 0) on a good response: m_rdata takes the slave slice anyway; the master ignores it.
REQ-030 err_clr and a new error in the same cycle: set wins, err_flag stays 1.
REQ-031 err_addr changes only on error, never on err_clr.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, s_valid=0, m_ready=0, m_rdata=0, s_addr/s_wdata=0, s_wstrb=0, s_instr=0, err_flag=0, err_addr=0, counter=0.
REQ-033 rst asserted mid-ACCESS aborts the transfer with no m_ready and no error; the first request after rst deasserts is handled normally.

Verification
REQ-034 Read at 0x1000_0004 (index 0), slave 0 ready in the first cycle with rdata 0x1234_5678 -> s_valid=4'b0001 for 1 cycle, m_ready 2 cycles after request, m_rdata=0x1234_5678.
REQ-035 Write at 0x4000_0000, wstrb=4'b0011, slave 1 ready after 5 cycles -> s_wstrb=4'b0011 and s_wdata stable for 5 cycles, one m_ready pulse, err_flag=0.
REQ-036 NUM_SLAVES=3, read at 0xC000_0000 -> no s_valid, m_ready at +2, m_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0xC000_0000.
REQ-037 TIMEOUT=8, slave 2 never ready -> s_valid[2] high exactly 8 cycles, then ERROR, m_ready with 0xDEAD_BEEF; a second run with ready on cycle 8 completes normally with no error.
REQ-038 err_clr pulsed in the same cycle as the ERROR state -> err_flag stays 1; err_clr alone later -> err_flag=0, err_addr unchanged.
REQ-039 rst pulsed during the third ACCESS cycle -> s_valid=0 immediately, no m_ready, next request completes in 2 cycles.
